spi_transaction_fsm: RTL and testbench

//   Sequences one SPI-slave memory transaction around the shift register.

---
 rtl/spi_transaction_fsm.sv | 136 +++++++++++++
 tb/tb_spi_transaction_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_fsm.sv
// rtl/spi_transaction_fsm.sv - SPI-slave memory transaction sequencer (header, read/write data phases)
// Outputs are registered from the next state so they decode state only, with no input-to-output path.
module spi_transaction_fsm #(
    parameter int width = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cs,
    input  logic sclk_pos,
    input  logic sclk_neg,
    input  logic rw_bit,
    output logic addr_we,
    output logic sr_load,
    output logic dm_we,
    output logic miso_en,
    output logic busy
);
    localparam int CW = $clog2(width + 1);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_GET_ADDR     = 3'd1,
        S_GOT_ADDR     = 3'd2,
        S_READ_LOAD    = 3'd3,
        S_READ_SHIFT   = 3'd4,
        S_WRITE_SHIFT  = 3'd5,
        S_WRITE_COMMIT = 3'd6,
        S_DONE         = 3'd7
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_next_count;
    logic          r_addr_we;
    logic          r_sr_load;
    logic          r_dm_we;
    logic          r_miso_en;
    logic          r_busy;

    // cs high wins over every other event, including the final data pulse
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        if (cs) begin
            w_next_state = S_IDLE;
            w_next_count = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = S_GET_ADDR;
                    w_next_count = '0;
                end
                S_GET_ADDR: begin
                    if (sclk_pos) begin
                        if (r_count == LAST) begin
                            w_next_state = S_GOT_ADDR;
                            w_next_count = '0;
                        end else begin
                            w_next_count = r_count + 1'b1;
                        end
                    end
                end
                S_GOT_ADDR: begin
                    w_next_state = rw_bit ? S_READ_LOAD : S_WRITE_SHIFT;
                    w_next_count = '0;
                end
                S_READ_LOAD: begin
                    if (sclk_neg) begin
                        w_next_state = S_READ_SHIFT;
                        w_next_count = '0;
                    end
                end
                S_READ_SHIFT: begin
                    if (sclk_neg) begin
                        if (r_count == LAST) begin
                            w_next_state = S_DONE;
                            w_next_count = '0;
                        end else begin
                            w_next_count = r_count + 1'b1;
                        end
                    end
                end
                S_WRITE_SHIFT: begin
                    if (sclk_pos) begin
                        if (r_count == LAST) begin
                            w_next_state = S_WRITE_COMMIT;
                            w_next_count = '0;
                        end else begin
                            w_next_count = r_count + 1'b1;
                        end
                    end
                end
                S_WRITE_COMMIT: begin
                    w_next_state = S_DONE;
                    w_next_count = '0;
                end
                S_DONE: begin
                    w_next_state = S_DONE;
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_count = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_addr_we <= 1'b0;
            r_sr_load <= 1'b0;
            r_dm_we   <= 1'b0;
            r_miso_en <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_next_count;
            r_addr_we <= (w_next_state == S_GOT_ADDR);
            r_sr_load <= (w_next_state == S_READ_LOAD);
            r_dm_we   <= (w_next_state == S_WRITE_COMMIT);
            r_miso_en <= (w_next_state == S_READ_SHIFT);
            r_busy    <= (w_next_state != S_IDLE);
        end
    end

    assign addr_we = r_addr_we;
    assign sr_load = r_sr_load;
    assign dm_we   = r_dm_we;
    assign miso_en = r_miso_en;
    assign busy    = r_busy;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// tb/tb_spi_transaction_fsm.sv - self-checking bench for spi_transaction_fsm
module tb_spi_transaction_fsm;
    logic clk = 1'b0;
    logic rst;
    logic cs;
    logic sclk_pos;
    logic sclk_neg;
    logic rw_bit;
    logic addr_we;
    logic sr_load;
    logic dm_we;
    logic miso_en;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_addr = 0;
    int n_dm = 0;
    int n_miso = 0;

    always #5 clk = ~clk;

    spi_transaction_fsm #(.width(8)) dut (
        .clk     (clk),
        .reset   (rst),
        .cs      (cs),
        .sclk_pos(sclk_pos),
        .sclk_neg(sclk_neg),
        .rw_bit  (rw_bit),
        .addr_we (addr_we),
        .sr_load (sr_load),
        .dm_we   (dm_we),
        .miso_en (miso_en),
        .busy    (busy)
    );

    // Transaction model: tracks pulses seen per phase rather than machine states
    bit m_in = 0;
    bit m_addr = 0;
    bit m_rd = 0;
    bit m_wait = 0;
    bit m_commit = 0;
    int m_hdr = 0;
    int m_dcnt = 0;

    function automatic void m_clear();
        m_in = 0; m_addr = 0; m_rd = 0; m_wait = 0; m_commit = 0;
        m_hdr = 0; m_dcnt = 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_clear();
        else if (cs) m_clear();
        else if (!m_in) begin
            m_clear();
            m_in = 1;
        end else if (m_hdr < 8) begin
            if (sclk_pos) begin
                m_hdr++;
                m_addr = (m_hdr == 8);
            end
        end else if (m_addr) begin
            m_addr = 0;
            m_rd = rw_bit;
            m_wait = rw_bit;
            m_dcnt = 0;
        end else if (m_commit) begin
            m_commit = 0;
        end else if (m_rd && m_wait) begin
            if (sclk_neg) m_wait = 0;
        end else if (m_rd) begin
            if (sclk_neg && m_dcnt < 8) m_dcnt++;
        end else begin
            if (sclk_pos && m_dcnt < 8) begin
                m_dcnt++;
                m_commit = (m_dcnt == 8);
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_busy", busy, m_in);
        chk("model_addr_we", addr_we, m_addr);
        chk("model_sr_load", sr_load, m_rd && m_wait);
        chk("model_miso_en", miso_en, m_rd && !m_wait && (m_dcnt < 8));
        chk("model_dm_we", dm_we, m_commit);
    end

    task automatic step(input logic c, input logic p, input logic n, input logic r);
        cs = c; sclk_pos = p; sclk_neg = n; rw_bit = r;
        @(posedge clk);
        #2;
        if (addr_we) n_addr++;
        if (dm_we) n_dm++;
        if (miso_en) n_miso++;
    endtask

    task automatic header(input logic r);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, (i == 2), r);
            chk("hdr_addr_we", addr_we, (i == 7));
            if (i < 7) step(1'b0, 1'b0, 1'b0, r);
        end
        step(1'b0, 1'b0, 1'b0, r);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; rw_bit = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_busy", busy, 1'b0);
        chk("reset_addr_we", addr_we, 1'b0);
        chk("reset_sr_load", sr_load, 1'b0);
        chk("reset_dm_we", dm_we, 1'b0);
        chk("reset_miso_en", miso_en, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Write transaction
        n_addr = 0; n_dm = 0; n_miso = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wr_busy", busy, 1'b1);
        header(1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("wr_dm_we_latency", dm_we, (i == 7));
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("wr_done_dm_we", dm_we, 1'b0);
        chk("wr_done_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("done_traffic_busy", busy, 1'b1);
        chk_int("wr_addr_we_cycles", n_addr, 1);
        chk_int("wr_dm_we_cycles", n_dm, 1);
        chk_int("wr_miso_cycles", n_miso, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wr_cs_high_idle", busy, 1'b0);

        // Back-to-back read with a same-clk pos+neg pulse in the header
        n_addr = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rd_busy", busy, 1'b1);
        header(1'b1);
        chk("rd_sr_load", sr_load, 1'b1);
        chk("rd_miso_before", miso_en, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("rd_sr_load_hold", sr_load, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("rd_miso_on", miso_en, 1'b1);
        chk("rd_sr_load_off", sr_load, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            chk("rd_miso_window", miso_en, (i < 7));
            step(1'b0, 1'b1, 1'b0, 1'b1);
        end
        chk("rd_done_busy", busy, 1'b1);
        chk_int("rd_addr_we_cycles", n_addr, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Aborted write after 5 data pulses
        n_dm = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        header(1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("abort_idle", busy, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_int("abort_dm_we_cycles", n_dm, 0);

        // Asynchronous reset in READ_SHIFT with count=3
        step(1'b0, 1'b0, 1'b0, 1'b1);
        header(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("pre_reset_miso", miso_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_miso", miso_en, 1'b0);
        chk("async_rst_sr_load", sr_load, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_dm = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        header(1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk_int("post_rst_dm_we_cycles", n_dm, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("final_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
